// File: rtl/adc_sampler.sv
// adc_sampler: tick-paced 16-SCLK serial ADC frame reader producing a signed, offset-removed, scaled sample.
// Optional ADC_FILTER_EN adds a 2-tap average stage (extra FILT cycle before publishing).
module adc_sampler #(
  parameter int N          = 19,
  parameter int SCLK_DIV   = 4,
  parameter int SAMPLE_DIV = 50000,
  parameter int OFFSET     = 2048,
  parameter int SHIFT      = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable,
  input  logic         sdata,
  output logic         cs_n,
  output logic         sclk,
  output logic [N-1:0] yk_act,
  output logic         en_reg,
  output logic         busy,
  output logic         overrun
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [CW-1:0]      CNT_LAST = CW'(SAMPLE_DIV - 1);
  localparam logic [DW-1:0]      DIV_LAST = DW'(SCLK_DIV - 1);
  localparam logic signed [12:0] OFF13    = 13'(OFFSET);

`ifdef ADC_FILTER_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PUBLISH, S_FILT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PUBLISH} state_t;
`endif

  state_t        state, state_nxt;
  logic [CW-1:0] tick_cnt, cnt_nxt;
  logic [DW-1:0] div_cnt, div_nxt;
  logic [3:0]    bit_cnt, bit_nxt;
  logic          sclk_q, sclk_nxt;
  logic          cs_n_q, cs_nxt;
  logic [15:0]   sreg, sreg_nxt;
  logic [N-1:0]  yk_q, yk_nxt;
  logic          en_q, en_nxt;
  logic          ovr_q, ovr_nxt;
  logic          tick;

  logic signed [12:0]  diff;
  logic signed [N-1:0] value;

  // The leading zero bit of the frame shifts off the top and is never decoded.
  logic hdr_unused;
  assign hdr_unused = sreg[15];

`ifdef ADC_FILTER_EN
  logic [N-1:0] val_q, val_nxt;
  logic [N-1:0] prev_q, prev_nxt;
  logic [N:0]   sum;
`endif

  assign tick  = enable && (tick_cnt == CNT_LAST);
  assign diff  = signed'({1'b0, sreg[11:0]}) - OFF13;
  assign value = N'(diff) <<< SHIFT;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = '0;
    div_nxt   = div_cnt;
    bit_nxt   = bit_cnt;
    sclk_nxt  = sclk_q;
    cs_nxt    = cs_n_q;
    sreg_nxt  = sreg;
    yk_nxt    = yk_q;
    en_nxt    = 1'b0;
    ovr_nxt   = ovr_q | (tick && (state != S_IDLE));
`ifdef ADC_FILTER_EN
    val_nxt   = val_q;
    prev_nxt  = prev_q;
    sum       = {val_q[N-1], val_q} + {prev_q[N-1], prev_q};
`endif

    if (enable && !tick) begin
      cnt_nxt = tick_cnt + CW'(1);
    end

    case (state)
      S_IDLE: begin
        if (tick) begin
          state_nxt = S_SHIFT;
          cs_nxt    = 1'b0;
          sclk_nxt  = 1'b0;
          div_nxt   = '0;
          bit_nxt   = '0;
        end
      end
      S_SHIFT: begin
        if (div_cnt == DIV_LAST) begin
          div_nxt = '0;
          if (!sclk_q) begin
            sclk_nxt = 1'b1;
            sreg_nxt = {sreg[14:0], sdata};
          end else if (bit_cnt == 4'd15) begin
            // Frame complete: release the ADC and register the result on the same edge.
            state_nxt = S_PUBLISH;
            cs_nxt    = 1'b1;
`ifdef ADC_FILTER_EN
            val_nxt   = value;
`else
            yk_nxt    = value;
            en_nxt    = 1'b1;
`endif
          end else begin
            bit_nxt  = bit_cnt + 4'd1;
            sclk_nxt = 1'b0;
          end
        end else begin
          div_nxt = div_cnt + DW'(1);
        end
      end
      S_PUBLISH: begin
`ifdef ADC_FILTER_EN
        state_nxt = S_FILT;
        yk_nxt    = sum[N:1];
        en_nxt    = 1'b1;
        prev_nxt  = val_q;
`else
        state_nxt = S_IDLE;
`endif
      end
`ifdef ADC_FILTER_EN
      S_FILT: begin
        state_nxt = S_IDLE;
      end
`endif
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      sclk_q   <= 1'b1;
      cs_n_q   <= 1'b1;
      sreg     <= '0;
      yk_q     <= '0;
      en_q     <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= cnt_nxt;
      div_cnt  <= div_nxt;
      bit_cnt  <= bit_nxt;
      sclk_q   <= sclk_nxt;
      cs_n_q   <= cs_nxt;
      sreg     <= sreg_nxt;
      yk_q     <= yk_nxt;
      en_q     <= en_nxt;
      ovr_q    <= ovr_nxt;
    end
  end

`ifdef ADC_FILTER_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      val_q  <= '0;
      prev_q <= '0;
    end else begin
      val_q  <= val_nxt;
      prev_q <= prev_nxt;
    end
  end
`endif

  assign cs_n    = cs_n_q;
  assign sclk    = sclk_q;
  assign yk_act  = yk_q;
  assign en_reg  = en_q;
  assign busy    = (state != S_IDLE);
  assign overrun = ovr_q;

endmodule

// File: tb/tb_adc_sampler.sv
// tb_adc_sampler: directed checks of adc_sampler framing, conversion, cadence, enable/reset handling and overrun.
// Expected values follow the unfiltered build unless ADC_FILTER_EN is defined.
module tb_adc_sampler;
  localparam int N = 19;
`ifdef ADC_FILTER_EN
  localparam int PUB = 65;
`else
  localparam int PUB = 64;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         enable = 1'b0;
  logic         sdata = 1'b0;
  logic         cs_n, sclk, en_reg, busy, overrun;
  logic [N-1:0] yk_act;

  logic         rst2 = 1'b0;
  logic         en2 = 1'b0;
  logic         cs_n2, sclk2, en_reg2, busy2, overrun2;
  logic [N-1:0] yk2;

  int          tests = 0;
  int          errors = 0;
  logic [15:0] frame = 16'h0800;

  adc_sampler #(.N(N), .SCLK_DIV(2), .SAMPLE_DIV(100), .OFFSET(2048), .SHIFT(4)) u_dut (
    .clk(clk), .rst(rst), .enable(enable), .sdata(sdata), .cs_n(cs_n), .sclk(sclk),
    .yk_act(yk_act), .en_reg(en_reg), .busy(busy), .overrun(overrun)
  );

  adc_sampler #(.N(N), .SCLK_DIV(2), .SAMPLE_DIV(60), .OFFSET(2048), .SHIFT(4)) u_ovr (
    .clk(clk), .rst(rst2), .enable(en2), .sdata(sdata), .cs_n(cs_n2), .sclk(sclk2),
    .yk_act(yk2), .en_reg(en_reg2), .busy(busy2), .overrun(overrun2)
  );

  always #5 clk = ~clk;

  // ADC model: presents the next frame bit (MSB first) after each SCLK falling edge.
  int   nfall = 0;
  logic prev_sclk = 1'b1;
  always @(negedge clk) begin
    if (cs_n !== 1'b0) begin
      nfall = 0;
    end else begin
      if (sclk === 1'b0 && prev_sclk === 1'b1) nfall++;
      if (nfall >= 1 && nfall <= 16) sdata = frame[16 - nfall];
    end
    prev_sclk = sclk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic measure_frame(input string tag, input logic [15:0] fr, input logic [N-1:0] exp_y,
                               input int drop_at, output int wait_n);
    int cs_low, rises, en_off;
    logic prev;
    logic [N-1:0] y;
    logic b_at, c_at, s_at;
    frame  = fr;
    wait_n = 0;
    y      = '0;
    b_at   = 1'b0;
    c_at   = 1'b0;
    s_at   = 1'b0;
    while (cs_n !== 1'b0 && wait_n < 400) begin
      step();
      wait_n++;
    end
    if (cs_n !== 1'b0) begin
      check({tag, "/cs_fall"}, 32'(cs_n), 32'd0);
      return;
    end
    cs_low = 1;
    rises  = 0;
    en_off = -1;
    prev   = sclk;
    for (int i = 1; i <= 150 && en_off < 0; i++) begin
      if (i == drop_at) enable = 1'b0;
      step();
      if (cs_n === 1'b0) cs_low++;
      if (sclk === 1'b1 && prev === 1'b0) rises++;
      prev = sclk;
      if (en_reg === 1'b1) begin
        en_off = i;
        y      = yk_act;
        b_at   = busy;
        c_at   = cs_n;
        s_at   = sclk;
      end
    end
    check({tag, "/cs_low"}, 32'(cs_low), 32'd64);
    check({tag, "/sclk_rises"}, 32'(rises), 32'd16);
    check({tag, "/en_offset"}, 32'(en_off), 32'(PUB));
    check({tag, "/yk_act"}, 32'(y), 32'(exp_y));
    check({tag, "/cs_sclk_busy_at_en"}, 32'({c_at, s_at, b_at}), 32'b111);
    step();
    check({tag, "/en_width"}, 32'(en_reg), 32'd0);
    check({tag, "/yk_hold"}, 32'(yk_act), 32'(exp_y));
    check({tag, "/busy_after"}, 32'(busy), 32'd0);
  endtask

  logic [15:0]  fr_tab [5] = '{16'h0FFF, 16'h0000, 16'hF800, 16'h0A5C, 16'h0123};
`ifdef ADC_FILTER_EN
  logic [N-1:0] ex_tab [5] = '{19'h03FF8, 19'h7FFF8, 19'h7C000, 19'h012E0, 19'h7DBF8};
  localparam logic [N-1:0] EX_DROP = 19'h7DBF8;
  localparam logic [N-1:0] EX_REEN = 19'h012E0;
  localparam logic [N-1:0] EX_POST = 19'h03FF8;
`else
  logic [N-1:0] ex_tab [5] = '{19'h07FF0, 19'h78000, 19'h00000, 19'h025C0, 19'h79230};
  localparam logic [N-1:0] EX_DROP = 19'h025C0;
  localparam logic [N-1:0] EX_REEN = 19'h00000;
  localparam logic [N-1:0] EX_POST = 19'h07FF0;
`endif

  initial begin
    int w, pulses, last, badgap, falls, k;

    repeat (3) step();
    check("rst/cs_n", 32'(cs_n), 32'd1);
    check("rst/sclk", 32'(sclk), 32'd1);
    check("rst/yk_act", 32'(yk_act), 32'd0);
    check("rst/en_reg", 32'(en_reg), 32'd0);
    check("rst/busy", 32'(busy), 32'd0);
    check("rst/overrun", 32'(overrun), 32'd0);

    rst = 1'b1;
    step();
    enable = 1'b1;
    measure_frame("mid", 16'h0800, 19'h00000, 0, w);
    check("mid/first_tick", 32'(w), 32'd100);

    for (int f = 0; f < 5; f++) begin
      measure_frame($sformatf("code%0d", f), fr_tab[f], ex_tab[f], 0, w);
    end

    pulses = 0;
    last   = -1;
    badgap = 0;
    for (int c = 0; c < 1000; c++) begin
      step();
      if (en_reg === 1'b1) begin
        if (last >= 0 && c - last != 100) badgap++;
        last = c;
        pulses++;
      end
    end
    check("cadence/pulses", 32'(pulses), 32'd10);
    check("cadence/gaps", 32'(badgap), 32'd0);
    check("cadence/overrun", 32'(overrun), 32'd0);

    measure_frame("drop", 16'h0A5C, EX_DROP, 10, w);
    falls = 0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (cs_n === 1'b0) falls++;
    end
    check("drop/no_frames", 32'(falls), 32'd0);
    enable = 1'b1;
    measure_frame("reen", 16'h0800, EX_REEN, 0, w);
    check("reen/first_tick", 32'(w), 32'd100);

    frame = 16'h0FFF;
    k = 0;
    while (cs_n !== 1'b0 && k < 200) begin
      step();
      k++;
    end
    check("rstmid/cs_fall", 32'(cs_n), 32'd0);
    repeat (18) step();
    rst = 1'b0;
    step();
    check("rstmid/cs_n", 32'(cs_n), 32'd1);
    check("rstmid/sclk", 32'(sclk), 32'd1);
    check("rstmid/yk_act", 32'(yk_act), 32'd0);
    check("rstmid/busy", 32'(busy), 32'd0);
    check("rstmid/en_reg", 32'(en_reg), 32'd0);
    rst = 1'b1;
    pulses = 0;
    falls  = 0;
    for (int c = 0; c < 90; c++) begin
      step();
      if (en_reg === 1'b1) pulses++;
      if (cs_n === 1'b0) falls++;
    end
    check("rstmid/no_publish", 32'(pulses), 32'd0);
    check("rstmid/no_frame", 32'(falls), 32'd0);
    measure_frame("postrst", 16'h0FFF, EX_POST, 0, w);
    check("postrst/tick", 32'(w), 32'd10);
    check("postrst/overrun", 32'(overrun), 32'd0);

    rst2 = 1'b1;
    step();
    en2 = 1'b1;
    repeat (100) step();
    check("ovr/before", 32'(overrun2), 32'd0);
    repeat (30) step();
    check("ovr/set", 32'(overrun2), 32'd1);
    en2 = 1'b0;
    repeat (100) step();
    check("ovr/sticky", 32'(overrun2), 32'd1);
    rst2 = 1'b0;
    step();
    check("ovr/cleared", 32'(overrun2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
